// File: rtl/kb_digit_accumulator.sv
// -----------------------------------------------------------------------------
// kb_digit_accumulator
//
// Purpose:
//   Consumes the raw PS/2 set-2 scancode byte stream, tracks break (F0) and
//   extended (E0) prefixes, maps accepted make codes to 4-bit key codes and
//   accumulates up to DIGITS decimal digits into a packed BCD entry buffer.
//   An operator (+, -) or Enter key hands the buffer to the downstream
//   arithmetic unit as operand/op_code and clears the entry buffer.
//
// Ports:
//   clk          in   system clock, all state on rising edge
//   rst          in   asynchronous active-high reset
//   kb_valid     in   one-cycle strobe, kb_data holds a complete byte
//   kb_data      in   received scancode byte
//   key_valid    out  one-cycle pulse, key_code valid
//   key_code     out  0-9 digits, A=+, B=-, C=Enter, D=Backspace (held)
//   digits       out  packed BCD entry, most recent digit in [3:0]
//   digit_count  out  number of digits currently held (0..DIGITS)
//   overflow     out  sticky, digit entered while buffer full
//   op_valid     out  one-cycle pulse, operand/op_code valid
//   operand      out  BCD value captured at operator/Enter (held)
//   op_code      out  0=+, 1=-, 2=Enter (held)
// -----------------------------------------------------------------------------
module kb_digit_accumulator #(
    parameter int  DIGITS = 4,
    localparam int CNT_W  = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  kb_valid,
    input  logic [7:0]            kb_data,
    output logic                  key_valid,
    output logic [3:0]            key_code,
    output logic [4*DIGITS-1:0]   digits,
    output logic [CNT_W-1:0]      digit_count,
    output logic                  overflow,
    output logic                  op_valid,
    output logic [4*DIGITS-1:0]   operand,
    output logic [1:0]            op_code
);

    localparam int DW = 4 * DIGITS;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    localparam logic [3:0] KEY_PLUS  = 4'hA;
    localparam logic [3:0] KEY_MINUS = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hC;
    localparam logic [3:0] KEY_BKSP  = 4'hD;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BRK,
        S_EXT,
        S_EXT_BRK
    } state_e;

    state_e             state_q;
    logic               key_valid_q;
    logic [3:0]         key_code_q;
    logic [DW-1:0]      digits_q;
    logic [CNT_W-1:0]   digit_count_q;
    logic               overflow_q;
    logic               op_valid_q;
    logic [DW-1:0]      operand_q;
    logic [1:0]         op_code_q;

    logic               map_hit;
    logic [3:0]         map_code;
    logic               emit_d;
    logic [3:0]         emit_code_d;

    // Non-extended make-code lookup. Prefix bytes and anything not listed
    // are misses, so they never produce a key.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        map_hit  = 1'b1;
        map_code = 4'h0;
        case (kb_data)
            8'h45:   map_code = 4'd0;
            8'h16:   map_code = 4'd1;
            8'h1E:   map_code = 4'd2;
            8'h26:   map_code = 4'd3;
            8'h25:   map_code = 4'd4;
            8'h2E:   map_code = 4'd5;
            8'h36:   map_code = 4'd6;
            8'h3D:   map_code = 4'd7;
            8'h3E:   map_code = 4'd8;
            8'h46:   map_code = 4'd9;
            8'h79:   map_code = KEY_PLUS;
            8'h7B:   map_code = KEY_MINUS;
            8'h5A:   map_code = KEY_ENTER;
            8'h66:   map_code = KEY_BKSP;
            default: map_hit  = 1'b0;
        endcase
    end

    // A key completes either on a mapped byte in IDLE or on E0 5A
    // (keypad Enter). Every other byte only moves the prefix tracker.
    always_comb begin
        emit_d      = 1'b0;
        emit_code_d = 4'h0;
        if (kb_valid) begin
            if (state_q == S_IDLE && map_hit) begin
                emit_d      = 1'b1;
                emit_code_d = map_code;
            end else if (state_q == S_EXT && kb_data == SC_ENTER) begin
                emit_d      = 1'b1;
                emit_code_d = KEY_ENTER;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every register here is a plain flop, none is a memory
            // array, so all of them take the asynchronous reset.
            state_q       <= S_IDLE;
            key_valid_q   <= 1'b0;
            key_code_q    <= 4'h0;
            digits_q      <= '0;
            digit_count_q <= '0;
            overflow_q    <= 1'b0;
            op_valid_q    <= 1'b0;
            operand_q     <= '0;
            op_code_q     <= 2'd0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // right-hand side reads the pre-edge value of each register.
            key_valid_q <= 1'b0;
            op_valid_q  <= 1'b0;

            if (kb_valid) begin
                case (state_q)
                    S_IDLE: begin
                        if (kb_data == SC_BREAK)    state_q <= S_BRK;
                        else if (kb_data == SC_EXT) state_q <= S_EXT;
                        else                        state_q <= S_IDLE;
                    end
                    S_EXT: begin
                        if (kb_data == SC_BREAK) state_q <= S_EXT_BRK;
                        else                     state_q <= S_IDLE;
                    end
                    // Release byte of a normal or extended key: discarded.
                    S_BRK, S_EXT_BRK: state_q <= S_IDLE;
                    default:          state_q <= S_IDLE;
                endcase
            end

            if (emit_d) begin
                key_valid_q <= 1'b1;
                key_code_q  <= emit_code_d;

                if (emit_code_d <= 4'd9) begin
                    if (digit_count_q < CNT_FULL) begin
                        digits_q      <= (digits_q << 4) | DW'(emit_code_d);
                        digit_count_q <= digit_count_q + CNT_W'(1);
                    end else begin
                        overflow_q <= 1'b1;
                    end
                end else if (emit_code_d == KEY_BKSP) begin
                    if (digit_count_q != '0) begin
                        digits_q      <= digits_q >> 4;
                        digit_count_q <= digit_count_q - CNT_W'(1);
                    end
                end else begin
                    // Operator or Enter: hand off the entry, then clear it.
                    op_valid_q    <= 1'b1;
                    operand_q     <= digits_q;
                    digits_q      <= '0;
                    digit_count_q <= '0;
                    overflow_q    <= 1'b0;
                    case (emit_code_d)
                        KEY_PLUS:  op_code_q <= 2'd0;
                        KEY_MINUS: op_code_q <= 2'd1;
                        default:   op_code_q <= 2'd2;
                    endcase
                end
            end
        end
    end

    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign digits      = digits_q;
    assign digit_count = digit_count_q;
    assign overflow    = overflow_q;
    assign op_valid    = op_valid_q;
    assign operand     = operand_q;
    assign op_code     = op_code_q;

endmodule

// File: tb/tb_kb_digit_accumulator.sv
// -----------------------------------------------------------------------------
// tb_kb_digit_accumulator
//
// Directed scenarios followed by random keystroke sequences. Expected values
// come from a keystroke-level model: a queue of entered digits, a sticky
// overflow flag and the last handed-off operand.
// -----------------------------------------------------------------------------
module tb_kb_digit_accumulator;

    localparam int DIGITS = 4;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam int DW     = 4 * DIGITS;

    logic             clk = 1'b0;
    logic             rst;
    logic             kb_valid;
    logic [7:0]       kb_data;
    logic             key_valid;
    logic [3:0]       key_code;
    logic [DW-1:0]    digits;
    logic [CNT_W-1:0] digit_count;
    logic             overflow;
    logic             op_valid;
    logic [DW-1:0]    operand;
    logic [1:0]       op_code;

    kb_digit_accumulator #(.DIGITS(DIGITS)) dut (
        .clk         (clk),
        .rst         (rst),
        .kb_valid    (kb_valid),
        .kb_data     (kb_data),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .digits      (digits),
        .digit_count (digit_count),
        .overflow    (overflow),
        .op_valid    (op_valid),
        .operand     (operand),
        .op_code     (op_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Keystroke-level reference model.
    int            q[$];
    bit            m_ovf;
    logic [3:0]    m_kc;
    logic [DW-1:0] m_operand;
    logic [1:0]    m_opc;

    logic [7:0] digit_scan [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                    8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Numeric BCD value of the entry: digits in entry order, newest lowest.
    function automatic logic [DW-1:0] model_digits();
        logic [DW-1:0] v = '0;
        foreach (q[i]) v = v * 16 + DW'(q[i]);
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf     = 1'b0;
        m_kc      = 4'h0;
        m_operand = '0;
        m_opc     = 2'd0;
    endtask

    task automatic model_key(input int k, output bit opv);
        opv  = 1'b0;
        m_kc = 4'(k);
        if (k <= 9) begin
            if (q.size() < DIGITS) q.push_back(k);
            else                   m_ovf = 1'b1;
        end else if (k == 13) begin
            if (q.size() > 0) void'(q.pop_back());
        end else begin
            opv       = 1'b1;
            m_operand = model_digits();
            m_opc     = 2'(k - 10);
            q.delete();
            m_ovf     = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag, input bit exp_kv, input bit exp_ov);
        chk({tag, ".key_valid"},   32'(key_valid),   32'(exp_kv));
        chk({tag, ".key_code"},    32'(key_code),    32'(m_kc));
        chk({tag, ".digits"},      32'(digits),      32'(model_digits()));
        chk({tag, ".digit_count"}, 32'(digit_count), 32'(q.size()));
        chk({tag, ".overflow"},    32'(overflow),    32'(m_ovf));
        chk({tag, ".op_valid"},    32'(op_valid),    32'(exp_ov));
        chk({tag, ".operand"},     32'(operand),     32'(m_operand));
        chk({tag, ".op_code"},     32'(op_code),     32'(m_opc));
    endtask

    // Drive one cycle starting at a falling edge; the DUT's registered
    // response is visible at the next falling edge, where checks sample.
    task automatic step(input logic v, input logic [7:0] b);
        kb_valid = v;
        kb_data  = b;
        @(negedge clk);
    endtask

    task automatic send_quiet(input logic [7:0] b, input string tag);
        step(1'b1, b);
        check_outputs(tag, 1'b0, 1'b0);
    endtask

    task automatic send_key(input logic [7:0] b, input int k, input string tag);
        bit opv;
        step(1'b1, b);
        model_key(k, opv);
        check_outputs(tag, 1'b1, opv);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 8'h00);
        check_outputs(tag, 1'b0, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        kb_valid = 1'b0;
        kb_data  = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset", 1'b0, 1'b0);
        rst = 1'b0;

        // Three digits back-to-back.
        send_key(8'h16, 1, "t1_k1");
        send_key(8'h1E, 2, "t1_k2");
        send_key(8'h26, 3, "t1_k3");
        chk("t1_digits", 32'(digits), 32'h0123);
        chk("t1_count",  32'(digit_count), 32'd3);
        send_key(8'h5A, 12, "t1_clear");

        // Releases produce no pulse.
        send_key(8'h16, 1, "t2_k1");
        send_quiet(8'hF0, "t2_f0a");
        send_quiet(8'h16, "t2_rel1");
        send_key(8'h1E, 2, "t2_k2");
        send_quiet(8'hF0, "t2_f0b");
        send_quiet(8'h1E, "t2_rel2");
        chk("t2_digits", 32'(digits), 32'h0012);
        send_key(8'h5A, 12, "t2_clear");

        // Overflow, then + hands off and clears.
        send_key(8'h16, 1, "t3_k1");
        send_key(8'h1E, 2, "t3_k2");
        send_key(8'h26, 3, "t3_k3");
        send_key(8'h25, 4, "t3_k4");
        send_key(8'h2E, 5, "t3_k5");
        chk("t3_full_digits", 32'(digits), 32'h1234);
        chk("t3_overflow",    32'(overflow), 32'd1);
        send_key(8'h79, 10, "t3_plus");
        chk("t3_operand", 32'(operand), 32'h1234);
        chk("t3_cleared", 32'({digits, digit_count, overflow}), 32'd0);
        idle("t3_idle");

        // Backspace then minus.
        send_key(8'h16, 1, "t4_k1");
        send_key(8'h1E, 2, "t4_k2");
        send_key(8'h66, 13, "t4_bksp");
        chk("t4_digits", 32'(digits), 32'h0001);
        send_key(8'h7B, 11, "t4_minus");
        chk("t4_operand", 32'(operand), 32'h0001);
        chk("t4_opcode",  32'(op_code), 32'd1);

        // Extended Enter, extended release/other, unmapped byte.
        send_quiet(8'hE0, "t5_e0");
        send_key(8'h5A, 12, "t5_enter");
        chk("t5_opcode", 32'(op_code), 32'd2);
        send_quiet(8'hE0, "t5_e0b");
        send_quiet(8'hF0, "t5_f0");
        send_quiet(8'h5A, "t5_rel");
        send_quiet(8'hE0, "t5_e0c");
        send_quiet(8'h75, "t5_e075");
        send_quiet(8'h1C, "t5_unmapped");
        send_quiet(8'hE0, "t5_e0d");
        send_quiet(8'hE0, "t5_e0e0");
        send_key(8'h66, 13, "t5_bksp_empty");

        // Reset in the middle of a break prefix.
        send_key(8'h16, 1, "t6_k1");
        send_quiet(8'hF0, "t6_f0");
        kb_valid = 1'b0;
        rst      = 1'b1;
        model_reset();
        #1;
        check_outputs("t6_async_rst", 1'b0, 1'b0);
        @(negedge clk);
        check_outputs("t6_rst_hold", 1'b0, 1'b0);
        rst = 1'b0;
        send_key(8'h1E, 2, "t6_after");
        chk("t6_digits", 32'(digits), 32'h0002);

        // Random keystroke sequences.
        for (int n = 0; n < 400; n++) begin
            int act = $urandom_range(0, 9);
            if (act <= 3) begin
                int d = $urandom_range(0, 9);
                send_key(digit_scan[d], d, "rnd_digit");
                if ($urandom_range(0, 1) == 1) begin
                    send_quiet(8'hF0, "rnd_f0");
                    send_quiet(digit_scan[d], "rnd_rel");
                end
            end else if (act == 4) begin
                send_key(8'h79, 10, "rnd_plus");
            end else if (act == 5) begin
                send_key(8'h7B, 11, "rnd_minus");
            end else if (act == 6) begin
                if ($urandom_range(0, 1) == 1) send_quiet(8'hE0, "rnd_e0");
                send_key(8'h5A, 12, "rnd_enter");
            end else if (act == 7) begin
                send_key(8'h66, 13, "rnd_bksp");
            end else if (act == 8) begin
                logic [7:0] junk [4] = '{8'h75, 8'h6B, 8'h12, 8'hE0};
                send_quiet(8'hE0, "rnd_ext");
                if ($urandom_range(0, 1) == 1) begin
                    send_quiet(8'hF0, "rnd_ext_f0");
                    send_quiet(8'($urandom_range(0, 255)), "rnd_ext_rel");
                end else begin
                    send_quiet(junk[$urandom_range(0, 3)], "rnd_ext_other");
                end
            end else begin
                logic [7:0] unm [4] = '{8'h1C, 8'h00, 8'hAA, 8'h29};
                if ($urandom_range(0, 1) == 1) begin
                    send_quiet(8'hF0, "rnd_brk");
                    send_quiet(8'($urandom_range(0, 255)), "rnd_brk_any");
                end else begin
                    send_quiet(unm[$urandom_range(0, 3)], "rnd_unmapped");
                end
            end
            if ($urandom_range(0, 2) == 0) idle("rnd_idle");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
